psx_bus_engine: RTL and testbench

- Parametrised successor to the PSX controller clock generator.
- Runs a complete PSX pad transaction: ATT framing, divided PSX clock, LSB-first command shift-out and data shift-in per byte, ACK pulse detection with timeout.
- Sits between the game-side controller logic (which supplies the command bytes and consumes the response bytes) and the pad pins.

---
 rtl/psx_bus_engine.sv | 193 +++++++++++++++++++
 tb/tb_psx_bus_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_bus_engine.sv
// rtl/psx_bus_engine.sv - PSX pad transaction engine: ATT framing, divided clock, byte shift, ACK timeout
module psx_bus_engine #(
    parameter int CLK_DIV     = 4,
    parameter int MAX_BYTES   = 9,
    parameter int ATT_SETUP   = 16,
    parameter int ACK_TIMEOUT = 400,
    parameter int GAP_CLK     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             bytes_expected,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic [3:0]             c_counter,
    output logic                   busy,
    output logic                   READY,
    output logic                   err_f,
    output logic                   psx_att,
    output logic                   psx_clk,
    output logic                   psx_cmd,
    input  logic                   psx_dat,
    input  logic                   psx_ack
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_ACK_WAIT, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t                 state_q;
    logic [11:0]            cnt_q;
    logic [2:0]             bit_q;
    logic                   phase_q;   // 0: psx_clk low half, 1: high half
    logic [3:0]             nbytes_q;
    logic [3:0]             c_counter_q;
    logic [8*MAX_BYTES-1:0] tx_q;
    logic [8*MAX_BYTES-1:0] rx_q;
    logic [7:0]             rx_byte_q;
    logic                   ack_seen_q;
    logic                   dat_s1_q, dat_s2_q, ack_s1_q, ack_s2_q;
    logic                   busy_q, ready_q, err_q, att_q, clk_q, cmd_q;

    logic [127:0] tx_ext_d;
    logic [6:0]   first_idx_d, next_idx_d;
    logic         cmd_first_d, cmd_next_d;
    logic [7:0]   rx_byte_d;
    logic         len_ok_d;

    // tx is padded to 16 bytes so any 4-bit byte index selects a defined bit
    always_comb begin
        tx_ext_d = '0;
        tx_ext_d[8*MAX_BYTES-1:0] = tx_q;
        first_idx_d = {c_counter_q, 3'd0};
        next_idx_d  = {c_counter_q, 3'(bit_q + 3'd1)};
        cmd_first_d = tx_ext_d[first_idx_d];
        cmd_next_d  = tx_ext_d[next_idx_d];
        rx_byte_d   = {dat_s2_q, rx_byte_q[7:1]};
        len_ok_d    = (bytes_expected != 4'd0) && (bytes_expected <= 4'(MAX_BYTES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            nbytes_q    <= '0;
            c_counter_q <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_byte_q   <= '0;
            ack_seen_q  <= 1'b0;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            ack_s1_q    <= 1'b1;
            ack_s2_q    <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            att_q       <= 1'b1;
            clk_q       <= 1'b1;
            cmd_q       <= 1'b1;
        end else begin
            dat_s1_q <= psx_dat;
            dat_s2_q <= dat_s1_q;
            ack_s1_q <= psx_ack;
            ack_s2_q <= ack_s1_q;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        c_counter_q <= '0;
                        rx_q        <= '0;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        nbytes_q    <= bytes_expected;
                        tx_q        <= tx_data;
                        if (len_ok_d) begin
                            state_q <= S_SETUP;
                            busy_q  <= 1'b1;
                            att_q   <= 1'b0;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 12'(ATT_SETUP - 1)) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                        clk_q   <= 1'b0;
                        cmd_q   <= cmd_first_d;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != 12'(CLK_DIV - 1)) begin
                        cnt_q <= cnt_q + 12'd1;
                    end else begin
                        cnt_q <= '0;
                        if (!phase_q) begin
                            phase_q   <= 1'b1;
                            clk_q     <= 1'b1;
                            rx_byte_q <= rx_byte_d;
                            if (bit_q == 3'd7) begin
                                for (int k = 0; k < MAX_BYTES; k++) begin
                                    if (c_counter_q == 4'(k)) rx_q[8*k +: 8] <= rx_byte_d;
                                end
                                c_counter_q <= c_counter_q + 4'd1;
                            end
                        end else if (bit_q != 3'd7) begin
                            phase_q <= 1'b0;
                            clk_q   <= 1'b0;
                            bit_q   <= bit_q + 3'd1;
                            cmd_q   <= cmd_next_d;
                        end else begin
                            cmd_q <= 1'b1;
                            if (c_counter_q == nbytes_q) begin
                                state_q <= S_DONE;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                att_q   <= 1'b1;
                            end else begin
                                state_q    <= S_ACK_WAIT;
                                ack_seen_q <= 1'b0;
                            end
                        end
                    end
                end
                S_ACK_WAIT: begin
                    // a completed ACK pulse takes priority over a coincident timeout
                    if (ack_seen_q && ack_s2_q) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else if (cnt_q == 12'(ACK_TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        att_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                        if (!ack_s2_q) ack_seen_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 12'(GAP_CLK - 1)) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                        clk_q   <= 1'b0;
                        cmd_q   <= cmd_first_d;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_q;
    assign c_counter = c_counter_q;
    assign busy      = busy_q;
    assign READY     = ready_q;
    assign err_f     = err_q;
    assign psx_att   = att_q;
    assign psx_clk   = clk_q;
    assign psx_cmd   = cmd_q;
endmodule

// File: tb/tb_psx_bus_engine.sv
// tb/tb_psx_bus_engine.sv - directed bench for psx_bus_engine with a behavioural pad model
module tb_psx_bus_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bytes_expected = 4'd0;
    logic [71:0] tx_data = '0;
    logic [71:0] rx_data;
    logic [3:0]  c_counter;
    logic        busy, READY, err_f, psx_att, psx_clk, psx_cmd;
    logic        psx_dat = 1'b1;
    logic        psx_ack = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [7:0] pad_resp [16];
    int         ack_mode [16];
    logic [7:0] cmd_cap  [16];
    int         fall_cnt [16];
    int         pad_bit = 0, pad_byte = 0, att_falls = 0;
    int         ack_req_cnt = 0, ack_done_cnt = 0, ack_byte = 0;
    logic       prev_att = 1'b1, prev_clk = 1'b1;

    psx_bus_engine #(
        .CLK_DIV(4), .MAX_BYTES(9), .ATT_SETUP(16), .ACK_TIMEOUT(400), .GAP_CLK(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bytes_expected(bytes_expected),
        .tx_data(tx_data), .rx_data(rx_data), .c_counter(c_counter), .busy(busy),
        .READY(READY), .err_f(err_f), .psx_att(psx_att), .psx_clk(psx_clk),
        .psx_cmd(psx_cmd), .psx_dat(psx_dat), .psx_ack(psx_ack)
    );

    always #5 clk = ~clk;

    // Pad: drives dat on falling edges, captures cmd on rising edges, requests ACK per byte
    always @(psx_att or psx_clk) begin
        if (prev_att && !psx_att) begin
            pad_bit = 0;
            pad_byte = 0;
            att_falls++;
            for (int i = 0; i < 16; i++) begin
                fall_cnt[i] = 0;
                cmd_cap[i] = 8'h00;
            end
        end
        if (!psx_att && pad_byte < 16 && prev_clk && !psx_clk) begin
            fall_cnt[pad_byte]++;
            psx_dat = pad_resp[pad_byte][pad_bit];
        end
        if (!psx_att && pad_byte < 16 && !prev_clk && psx_clk) begin
            cmd_cap[pad_byte][pad_bit] = psx_cmd;
            if (pad_bit == 7) begin
                ack_byte = pad_byte;
                ack_req_cnt++;
                pad_bit = 0;
                pad_byte++;
            end else begin
                pad_bit++;
            end
        end
        prev_att = psx_att;
        prev_clk = psx_clk;
    end

    // ACK modes: 0 normal 20-cycle pulse, 1 withheld, 2 held low past timeout, 3 returns on timeout cycle
    always begin
        @(negedge clk);
        if (ack_req_cnt != ack_done_cnt) begin
            ack_done_cnt = ack_req_cnt;
            case (ack_mode[ack_byte])
                0: begin repeat (10) @(negedge clk); psx_ack = 1'b0; repeat (20)  @(negedge clk); psx_ack = 1'b1; end
                2: begin repeat (10) @(negedge clk); psx_ack = 1'b0; repeat (450) @(negedge clk); psx_ack = 1'b1; end
                3: begin repeat (10) @(negedge clk); psx_ack = 1'b0; repeat (391) @(negedge clk); psx_ack = 1'b1; end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] n, input logic [71:0] tx);
        @(negedge clk);
        bytes_expected = n;
        tx_data = tx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int busy_n, output logic ok);
        busy_n = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (READY || err_f) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic set_modes(input int m0);
        for (int i = 0; i < 16; i++) ack_mode[i] = 0;
        ack_mode[0] = m0;
    endtask

    initial begin
        int   n;
        int   att_before;
        logic ok;
        for (int i = 0; i < 16; i++) pad_resp[i] = 8'h00;
        set_modes(0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_att", psx_att, 1'b1);
        chk("reset_clk", psx_clk, 1'b1);
        chk("reset_cmd", psx_cmd, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", READY, 1'b0);
        chk("reset_err", err_f, 1'b0);
        chk("reset_cnt", c_counter, 4'd0);
        chk("reset_rx", rx_data, 72'h0);
        rst = 1'b0;

        // nominal 3-byte transaction
        pad_resp[0] = 8'hFF; pad_resp[1] = 8'h41; pad_resp[2] = 8'h5A;
        do_start(4'd3, 72'h004201);
        wait_end(2000, n, ok);
        chk("nom_end", ok, 1'b1);
        chk("nom_busy_cycles", n, 282);
        chk("nom_rx", rx_data, 72'h5A41FF);
        chk("nom_cnt", c_counter, 4'd3);
        chk("nom_ready", READY, 1'b1);
        chk("nom_err", err_f, 1'b0);
        chk("nom_att", psx_att, 1'b1);
        chk("nom_cmd0", cmd_cap[0], 8'h01);
        chk("nom_cmd1", cmd_cap[1], 8'h42);
        chk("nom_cmd2", cmd_cap[2], 8'h00);
        chk("nom_falls0", fall_cnt[0], 8);
        chk("nom_falls1", fall_cnt[1], 8);
        chk("nom_falls2", fall_cnt[2], 8);
        repeat (80) @(negedge clk);
        chk("late_ack_ready", READY, 1'b1);
        chk("late_ack_err", err_f, 1'b0);

        // ACK withheld after byte 1: error exactly ACK_TIMEOUT after ACK_WAIT entry (+CLK_DIV from last rise)
        set_modes(1);
        do_start(4'd3, 72'h004201);
        for (int i = 0; i < 500 && c_counter != 4'd1; i++) @(negedge clk);
        chk("to_first_byte", c_counter, 4'd1);
        n = 0;
        for (int i = 0; i < 1000 && !err_f; i++) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 404);
        chk("to_err", err_f, 1'b1);
        chk("to_att", psx_att, 1'b1);
        chk("to_cnt", c_counter, 4'd1);
        chk("to_busy", busy, 1'b0);

        // ACK held low throughout ACK_WAIT
        set_modes(2);
        do_start(4'd2, 72'h4201);
        wait_end(2000, n, ok);
        chk("hold_end", ok, 1'b1);
        chk("hold_err", err_f, 1'b1);
        chk("hold_cnt", c_counter, 4'd1);
        repeat (100) @(negedge clk);

        // ACK return coincides with the timeout cycle: ACK wins
        set_modes(3);
        do_start(4'd2, 72'h4201);
        wait_end(3000, n, ok);
        chk("sim_end", ok, 1'b1);
        chk("sim_ready", READY, 1'b1);
        chk("sim_err", err_f, 1'b0);
        chk("sim_cnt", c_counter, 4'd2);
        chk("sim_rx", rx_data, 72'h41FF);
        repeat (80) @(negedge clk);

        // illegal length 0
        set_modes(0);
        att_before = att_falls;
        do_start(4'd0, 72'h01);
        chk("len0_err", err_f, 1'b1);
        chk("len0_busy", busy, 1'b0);
        chk("len0_att", psx_att, 1'b1);
        repeat (20) @(negedge clk);
        chk("len0_no_att", att_falls, att_before);

        // single-byte transfer: no ACK phase
        pad_resp[0] = 8'hC3;
        do_start(4'd1, 72'h5A);
        wait_end(500, n, ok);
        chk("one_end", ok, 1'b1);
        chk("one_ready", READY, 1'b1);
        chk("one_rx", rx_data, 72'hC3);
        chk("one_cmd", cmd_cap[0], 8'h5A);
        repeat (80) @(negedge clk);

        // illegal length 10 > MAX_BYTES
        att_before = att_falls;
        do_start(4'd10, 72'h01);
        chk("len10_err", err_f, 1'b1);
        chk("len10_ready", READY, 1'b0);
        chk("len10_att", psx_att, 1'b1);
        repeat (20) @(negedge clk);
        chk("len10_no_att", att_falls, att_before);

        // reset during byte 2 bit 4
        pad_resp[0] = 8'hFF; pad_resp[1] = 8'h41; pad_resp[2] = 8'h5A;
        do_start(4'd3, 72'h004201);
        for (int i = 0; i < 1000 && !(pad_byte == 1 && pad_bit == 4); i++) @(negedge clk);
        chk("mid_reached", pad_bit, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_att", psx_att, 1'b1);
        chk("mid_clk", psx_clk, 1'b1);
        chk("mid_cmd", psx_cmd, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_rx", rx_data, 72'h0);
        chk("mid_cnt", c_counter, 4'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // clean restart; start pulse while busy must not disturb sampled data
        pad_resp[0] = 8'hA5; pad_resp[1] = 8'h96;
        do_start(4'd2, 72'h3C81);
        repeat (5) @(negedge clk);
        bytes_expected = 4'd5;
        tx_data = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(2000, n, ok);
        chk("rs_end", ok, 1'b1);
        chk("rs_ready", READY, 1'b1);
        chk("rs_cnt", c_counter, 4'd2);
        chk("rs_rx", rx_data, 72'h96A5);
        chk("rs_cmd0", cmd_cap[0], 8'h81);
        chk("rs_cmd1", cmd_cap[1], 8'h3C);
        repeat (80) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
